huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_pkg.sv | 74 +++++++
 rtl/huffman_decode_table.sv | 33 +++
 rtl/huffman_decoder.sv | 103 ++++++++++
 tb/tb_huffman_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared codebook and decoder types for the huffman encoder/decoder pair.
// Codes are canonical. Symbols are ranked as follows: twelve frequent
// characters come first, in a fixed order. The remaining ASCII values follow
// in ascending order. Ranks are then split into tiers of fixed length:
// 4 symbols x 3 bits, 8 x 6, 20 x 8 and 96 x 10. The Kraft sum is below 1,
// so some 10-bit patterns (for example all ones) decode to nothing.
package huffman_pkg;

  localparam int MAX_LEN = 10;
  localparam int NUM_SYM = 128;
  localparam int NUM_HOT = 12;

  // Rank boundaries of each length tier.
  localparam int TIER0_END = 4;   // 3-bit codes
  localparam int TIER1_END = 12;  // 6-bit codes
  localparam int TIER2_END = 32;  // 8-bit codes; 10-bit codes above this rank

  // First canonical code of each tier.
  localparam int BASE0 = 0;
  localparam int BASE1 = 32;
  localparam int BASE2 = 160;
  localparam int BASE3 = 720;

  // Frequent characters in rank order: ' ' e t a o i n s h r d l
  localparam logic [6:0] HOT_SYM [NUM_HOT] = '{
    7'h20, 7'h65, 7'h74, 7'h61, 7'h6F, 7'h69,
    7'h6E, 7'h73, 7'h68, 7'h72, 7'h64, 7'h6C
  };

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OUTPUT  = 2'd1,
    ERROR   = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic [6:0] ascii;
    logic       match;
  } lookup_t;

  function automatic int cb_rank(input int a);
    int below;
    int rank;
    below = 0;
    rank  = -1;
    for (int k = 0; k < NUM_HOT; k++) begin
      if (int'(HOT_SYM[k]) == a) rank = k;
      if (int'(HOT_SYM[k]) < a) below++;
    end
    if (rank < 0) rank = NUM_HOT + a - below;
    return rank;
  endfunction

  function automatic logic [3:0] cb_len(input int a);
    int r;
    r = cb_rank(a);
    if (r < TIER0_END)      return 4'd3;
    else if (r < TIER1_END) return 4'd6;
    else if (r < TIER2_END) return 4'd8;
    else                    return 4'd10;
  endfunction

  function automatic logic [MAX_LEN-1:0] cb_code(input int a);
    int r;
    int v;
    r = cb_rank(a);
    if (r < TIER0_END)      v = BASE0 + r;
    else if (r < TIER1_END) v = BASE1 + r - TIER0_END;
    else if (r < TIER2_END) v = BASE2 + r - TIER1_END;
    else                    v = BASE3 + r - TIER2_END;
    return MAX_LEN'(v);
  endfunction

endpackage

// File: rtl/huffman_decode_table.sv
// Combinational reverse codebook: (code, len) -> (ascii, match).
// There is one comparator per symbol, built from the shared codebook.
// Because the code is prefix-free, at most one comparator fires, so the
// ascii outputs can simply be ORed together.
module huffman_decode_table #(
  parameter int MAX_LEN = huffman_pkg::MAX_LEN
) (
  input  logic [MAX_LEN-1:0] code,
  input  logic [3:0]         len,
  output logic [6:0]         ascii,
  output logic               match
);
  import huffman_pkg::*;

  logic [NUM_SYM-1:0] hit;

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_sym
    localparam int               L = int'(cb_len(i));
    localparam logic [MAX_LEN-1:0] C = MAX_LEN'(cb_code(i));
    localparam logic [MAX_LEN-1:0] M = MAX_LEN'((1 << L) - 1);
    assign hit[i] = (len == 4'(L)) && ((code & M) == C);
  end

  assign match = |hit;

  // OR-merge the one-hot hit vector into the symbol index
  always_comb begin
    ascii = '0;
    for (int i = 0; i < NUM_SYM; i++)
      if (hit[i]) ascii = ascii | 7'(i);
  end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial huffman decoder. Codeword bits are shifted in MSB first while
// the decoder is in COLLECT. After each shift, the shifted value is looked up
// in the shared codebook. A match is held in OUTPUT until the consumer takes
// it. If MAX_LEN bits arrive without a match, the decoder takes a one-cycle
// ERROR detour.
module huffman_decoder #(
  parameter int MAX_LEN = huffman_pkg::MAX_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [6:0]       ascii_out,
  output logic [3:0]       sym_len,
  output logic             ascii_valid,
  input  logic             out_ready,
  output logic             error,
  output logic [CNT_W-1:0] sym_count
);
  import huffman_pkg::*;

  dec_state_t         state;
  logic [MAX_LEN-1:0] acc;
  logic [3:0]         len;
  logic [MAX_LEN-1:0] acc_nxt;
  logic [3:0]         len_nxt;
  lookup_t            lk;
  logic               accept;
  logic               xfer;

  assign acc_nxt   = {acc[MAX_LEN-2:0], bit_in};
  assign len_nxt   = len + 4'd1;
  assign bit_ready = (state == COLLECT);
  assign accept    = bit_valid & bit_ready;
  assign xfer      = ascii_valid & out_ready;

  huffman_decode_table #(.MAX_LEN(MAX_LEN)) u_table (
    .code  (acc_nxt),
    .len   (len_nxt),
    .ascii (lk.ascii),
    .match (lk.match)
  );

  // Decoder FSM. Flush takes priority over any accept or transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      acc         <= '0;
      len         <= '0;
      ascii_out   <= '0;
      sym_len     <= '0;
      ascii_valid <= 1'b0;
      error       <= 1'b0;
      sym_count   <= '0;
    end else if (flush) begin
      state       <= COLLECT;
      acc         <= '0;
      len         <= '0;
      ascii_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          error <= 1'b0;
          if (accept) begin
            if (lk.match) begin
              ascii_out   <= lk.ascii;
              sym_len     <= len_nxt;
              ascii_valid <= 1'b1;
              acc         <= '0;
              len         <= '0;
              state       <= OUTPUT;
            end else if (len_nxt == 4'(MAX_LEN)) begin
              acc   <= '0;
              len   <= '0;
              error <= 1'b1;
              state <= ERROR;
            end else begin
              acc <= acc_nxt;
              len <= len_nxt;
            end
          end
        end
        OUTPUT: begin
          if (xfer) begin
            ascii_valid <= 1'b0;
            sym_count   <= sym_count + CNT_W'(1);
            state       <= COLLECT;
          end
        end
        ERROR: begin
          error <= 1'b0;
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: a table of hand-computed
// codewords, hand-written sequences for hold/flush/reset, and a randomized
// round trip of all 128 symbols against a codebook built here.
module tb_huffman_decoder;
  localparam int MAX_LEN = 10;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  logic             bit_ready;
  logic [6:0]       ascii_out;
  logic [3:0]       sym_len;
  logic             ascii_valid;
  logic             error;
  logic [CNT_W-1:0] sym_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  huffman_decoder #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .ascii_out(ascii_out),
    .sym_len(sym_len), .ascii_valid(ascii_valid), .out_ready(out_ready),
    .error(error), .sym_count(sym_count)
  );

  // Reference codebook: canonical assignment over a priority order
  logic [MAX_LEN-1:0] ref_code [128];
  int                 ref_len  [128];

  task automatic build_ref();
    int order[$];
    int hot [12] = '{32, 101, 116, 97, 111, 105, 110, 115, 104, 114, 100, 108};
    int tier_len [4] = '{3, 6, 8, 10};
    int tier_cnt [4] = '{4, 8, 20, 96};
    int code;
    int prev;
    int idx;
    bit is_hot;
    for (int k = 0; k < 12; k++) order.push_back(hot[k]);
    for (int a = 0; a < 128; a++) begin
      is_hot = 1'b0;
      for (int k = 0; k < 12; k++) if (hot[k] == a) is_hot = 1'b1;
      if (!is_hot) order.push_back(a);
    end
    code = 0; prev = tier_len[0]; idx = 0;
    for (int t = 0; t < 4; t++)
      for (int k = 0; k < tier_cnt[t]; k++) begin
        code = code << (tier_len[t] - prev);
        prev = tier_len[t];
        ref_code[order[idx]] = MAX_LEN'(code);
        ref_len[order[idx]]  = tier_len[t];
        code++;
        idx++;
      end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive len bits MSB first, one per cycle; returns at the negedge after the last accept
  task automatic send_code(input logic [MAX_LEN-1:0] code, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = code[i];
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  typedef struct {
    logic [MAX_LEN-1:0] code;
    int                 len;
    logic               exp_err;
    logic [6:0]         exp_ascii;
  } vec_t;

  vec_t vecs [10];

  task automatic round_trip();
    int order[$];
    logic bitq[$];
    int expq[$];
    int cyc;
    int got;
    int errs;
    int j;
    int tmp;
    for (int a = 0; a < 128; a++) order.push_back(a);
    for (int i = 127; i > 0; i--) begin
      j = $urandom_range(i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    foreach (order[k]) begin
      expq.push_back(order[k]);
      for (int b = ref_len[order[k]] - 1; b >= 0; b--) bitq.push_back(ref_code[order[k]][b]);
    end
    cyc = 0; got = 0; errs = 0;
    while (got < 128 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (error) errs++;
      out_ready = ($urandom_range(3) != 0);
      if (ascii_valid && out_ready) begin
        if (expq.size() == 0) check("rt_extra_symbol", 1, 0);
        else begin
          check("rt_ascii", ascii_out, expq[0]);
          check("rt_len", sym_len, ref_len[expq[0]]);
          void'(expq.pop_front());
        end
        got++;
      end
      bit_valid = (bitq.size() > 0) && ($urandom_range(2) != 0);
      bit_in    = (bitq.size() > 0) ? bitq[0] : 1'b0;
      if (bit_valid && bit_ready) void'(bitq.pop_front());
    end
    @(negedge clk);
    bit_valid = 1'b0;
    out_ready = 1'b1;
    exp_cnt += 128;
    check("rt_done", got, 128);
    check("rt_no_error", errs, 0);
    check("rt_count", sym_count, exp_cnt % 256);
  endtask

  initial begin
    build_ref();
    vecs[0] = '{10'b1011111100, 10, 1'b0, 7'h41};
    vecs[1] = '{10'b0000000000,  3, 1'b0, 7'h20};
    vecs[2] = '{10'b0000000001,  3, 1'b0, 7'h65};
    vecs[3] = '{10'b0000000010,  3, 1'b0, 7'h74};
    vecs[4] = '{10'b0000000011,  3, 1'b0, 7'h61};
    vecs[5] = '{10'b0000100000,  6, 1'b0, 7'h6F};
    vecs[6] = '{10'b0000100111,  6, 1'b0, 7'h6C};
    vecs[7] = '{10'b0010100000,  8, 1'b0, 7'h00};
    vecs[8] = '{10'b1111111111, 10, 1'b1, 7'h00};
    vecs[9] = '{10'b1100101111, 10, 1'b0, 7'h7F};

    // Reset state
    #12;
    check("rst_ascii", ascii_out, 0);
    check("rst_len", sym_len, 0);
    check("rst_valid", ascii_valid, 0);
    check("rst_error", error, 0);
    check("rst_count", sym_count, 0);
    check("rst_ready", bit_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back-to-back with out_ready held high
    foreach (vecs[v]) begin
      send_code(vecs[v].code, vecs[v].len);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_err", v), error, 1);
        check($sformatf("v%0d_err_ready", v), bit_ready, 0);
        check($sformatf("v%0d_err_valid", v), ascii_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_err_1cyc", v), error, 0);
        check($sformatf("v%0d_ready_back", v), bit_ready, 1);
      end else begin
        check($sformatf("v%0d_valid", v), ascii_valid, 1);
        check($sformatf("v%0d_ascii", v), ascii_out, vecs[v].exp_ascii);
        check($sformatf("v%0d_len", v), sym_len, vecs[v].len);
        exp_cnt++;
        @(negedge clk);
        check($sformatf("v%0d_valid_1cyc", v), ascii_valid, 0);
        check($sformatf("v%0d_count", v), sym_count, exp_cnt % 256);
      end
    end

    // Backpressure: hold 'e' for 5 cycles while bits are offered
    out_ready = 1'b0;
    send_code(10'b001, 3);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", ascii_valid, 1);
      check("hold_ascii", ascii_out, 7'h65);
      check("hold_ready", bit_ready, 0);
      check("hold_count", sym_count, exp_cnt % 256);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    out_ready = 1'b1;
    exp_cnt++;
    @(negedge clk);
    check("hold_release_valid", ascii_valid, 0);
    check("hold_release_count", sym_count, exp_cnt % 256);
    send_code(10'b010, 3);
    check("after_hold_ascii", ascii_out, 7'h74);
    exp_cnt++;
    @(negedge clk);

    // Flush after 3 bits of 'A', then flush a pending symbol
    send_code(10'b101, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", bit_ready, 1);
    out_ready = 1'b0;
    send_code(10'b001, 3);
    check("flush_partial_gone", ascii_valid, 1);
    check("flush_partial_ascii", ascii_out, 7'h65);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", ascii_valid, 0);
    check("flush_out_count", sym_count, exp_cnt % 256);
    @(negedge clk);
    check("flush_out_count2", sym_count, exp_cnt % 256);

    // Randomized round trip of every symbol
    round_trip();

    // Asynchronous reset mid-codeword
    send_code(10'b10, 2);
    rst_n = 1'b0;
    #1;
    check("arst_ascii", ascii_out, 0);
    check("arst_len", sym_len, 0);
    check("arst_valid", ascii_valid, 0);
    check("arst_error", error, 0);
    check("arst_count", sym_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a symbol is pending
    out_ready = 1'b0;
    send_code(10'b100000, 6);
    check("arst_out_pending", ascii_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", ascii_valid, 0);
    check("arst_out_ascii", ascii_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_code(10'b011, 3);
    check("post_rst_ascii", ascii_out, 7'h61);
    check("post_rst_len", sym_len, 3);
    @(negedge clk);
    check("post_rst_count", sym_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
